instr_mem_bootload: RTL and testbench

//  Parametrised instruction memory for the RISC-V fetch stage, reloadable at run time.

---
 rtl/instr_mem_bootload.sv | 184 ++++++++++++++++++
 tb/tb_instr_mem_bootload.sv | 328 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_mem_bootload.sv
// Instruction memory for the fetch stage, reloadable at run time over a byte-serial port.
// Ports:
//   clk, rst_n                     clock, synchronous active-low reset
//   fetch_en, fetch_addr           fetch request (byte address), fetch_en=0 stalls the pipeline
//   instr, instr_valid, fetch_fault fetch result after READ_LAT accepted cycles
//   ld_start, ld_byte_valid, ld_byte, ld_end   program-load byte stream
//   ld_busy, cpu_hold, ld_done, ld_err, ld_word_count   load status
module instr_mem_bootload #(
  parameter int unsigned ADDR_W      = 32,
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int unsigned READ_LAT    = 1,
  parameter logic [31:0] NOP_WORD    = 32'h0000_0013
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           fetch_en,
  input  logic [ADDR_W-1:0]              fetch_addr,
  output logic [31:0]                    instr,
  output logic                           instr_valid,
  output logic                           fetch_fault,
  input  logic                           ld_start,
  input  logic                           ld_byte_valid,
  input  logic [7:0]                     ld_byte,
  input  logic                           ld_end,
  output logic                           ld_busy,
  output logic                           cpu_hold,
  output logic                           ld_done,
  output logic                           ld_err,
  output logic [$clog2(DEPTH_WORDS):0]   ld_word_count
);

  localparam int unsigned AW = $clog2(DEPTH_WORDS);
  localparam int unsigned CW = AW + 1;
  localparam int unsigned IW = ADDR_W - 2;

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_DONE} state_t;

  state_t          state, state_nxt;
  logic [AW-1:0]   wr_ptr;
  logic [1:0]      byte_idx;
  logic [23:0]     lane_sr;
  logic            start_c, byte_c, word_c, last_c, end_c, err_set_c;

  // Storage is deliberately outside reset so an image survives a core reset.
  logic [31:0] mem [DEPTH_WORDS] = '{default: NOP_WORD};

  // Load FSM next-state and per-cycle load events.
  always_comb begin
    state_nxt = state;
    start_c   = 1'b0;
    byte_c    = 1'b0;
    word_c    = 1'b0;
    last_c    = 1'b0;
    end_c     = 1'b0;
    err_set_c = 1'b0;
    case (state)
      S_IDLE: begin
        if (ld_start) begin
          start_c   = 1'b1;
          state_nxt = S_LOAD;
        end
      end
      S_LOAD: begin
        if (ld_start) begin
          start_c = 1'b1;
        end else begin
          byte_c = ld_byte_valid;
          word_c = byte_c && (byte_idx == 2'd3);
          last_c = word_c && (wr_ptr == AW'(DEPTH_WORDS - 1));
          // A byte arriving with ld_end is taken first; only leftovers are an error.
          end_c     = ld_end && !last_c;
          err_set_c = end_c && !word_c && (byte_c || (byte_idx != 2'd0));
          if (last_c || ld_end) state_nxt = S_DONE;
        end
      end
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // Load pointers, counters and status outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr        <= '0;
      byte_idx      <= '0;
      ld_word_count <= '0;
      ld_err        <= 1'b0;
      ld_busy       <= 1'b0;
      ld_done       <= 1'b0;
    end else begin
      ld_busy <= (state_nxt != S_IDLE);
      ld_done <= (state_nxt == S_DONE);
      if (start_c) begin
        wr_ptr        <= '0;
        byte_idx      <= '0;
        ld_word_count <= '0;
        ld_err        <= 1'b0;
      end else begin
        if (byte_c) byte_idx <= byte_idx + 2'd1;
        if (word_c) begin
          ld_word_count <= ld_word_count + CW'(1);
          // The last word ends the load, so the pointer is never advanced past it.
          if (!last_c) wr_ptr <= wr_ptr + AW'(1);
        end
        if (end_c) byte_idx <= '0;
        if (err_set_c) ld_err <= 1'b1;
      end
    end
  end

  assign cpu_hold = ld_busy;

  // Byte assembly: bytes shift in from the top so the first byte lands in bits 7:0.
  always_ff @(posedge clk) begin
    if (byte_c) lane_sr <= {ld_byte, lane_sr[23:8]};
    if (word_c) mem[wr_ptr] <= {ld_byte, lane_sr};
  end

  // Fetch address decode.
  logic [IW-1:0] widx;
  logic [AW-1:0] rd_idx;
  logic          fault_c;

  always_comb begin
    widx    = fetch_addr[ADDR_W-1:2];
    rd_idx  = widx[AW-1:0];
    fault_c = (fetch_addr[1:0] != 2'b00) || ((widx >> AW) != '0);
  end

  // First fetch stage; frozen whenever fetch_en is low.
  logic [31:0] s1_instr;
  logic        s1_valid, s1_fault;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_instr <= NOP_WORD;
      s1_valid <= 1'b0;
      s1_fault <= 1'b0;
    end else if (fetch_en) begin
      if (state == S_IDLE) begin
        s1_instr <= fault_c ? NOP_WORD : mem[rd_idx];
        s1_valid <= 1'b1;
        s1_fault <= fault_c;
      end else begin
        s1_instr <= NOP_WORD;
        s1_valid <= 1'b0;
        s1_fault <= 1'b0;
      end
    end
  end

  // Optional second output stage, advancing in lockstep with the first.
  if (READ_LAT == 2) begin : g_lat2
    logic [31:0] s2_instr;
    logic        s2_valid, s2_fault;

    always_ff @(posedge clk) begin
      if (!rst_n) begin
        s2_instr <= NOP_WORD;
        s2_valid <= 1'b0;
        s2_fault <= 1'b0;
      end else if (fetch_en) begin
        s2_instr <= s1_instr;
        s2_valid <= s1_valid;
        s2_fault <= s1_fault;
      end
    end

    assign instr       = s2_instr;
    assign instr_valid = s2_valid;
    assign fetch_fault = s2_fault;
  end else begin : g_lat1
    assign instr       = s1_instr;
    assign instr_valid = s1_valid;
    assign fetch_fault = s1_fault;
  end

endmodule

// File: tb/tb_instr_mem_bootload.sv
// Bench for instr_mem_bootload: two instances (READ_LAT 1 and 2) share one stimulus stream
// and are compared each cycle against a transaction-level reference model.
module tb_instr_mem_bootload;

  localparam int unsigned DEPTH = 16;
  localparam int unsigned CW    = $clog2(DEPTH) + 1;
  localparam logic [31:0] NOP   = 32'h0000_0013;

  logic            clk = 1'b0;
  logic            rst_n, fetch_en, ld_start, ld_byte_valid, ld_end;
  logic [31:0]     fetch_addr;
  logic [7:0]      ld_byte;
  logic [31:0]     instr_a, instr_b;
  logic            valid_a, valid_b, fault_a, fault_b;
  logic            busy_a, busy_b, hold_a, hold_b, done_a, done_b, err_a, err_b;
  logic [CW-1:0]   cnt_a, cnt_b;

  always #5 clk = ~clk;

  instr_mem_bootload #(.ADDR_W(32), .DEPTH_WORDS(DEPTH), .READ_LAT(1), .NOP_WORD(NOP)) dut_a (
    .clk(clk), .rst_n(rst_n), .fetch_en(fetch_en), .fetch_addr(fetch_addr),
    .instr(instr_a), .instr_valid(valid_a), .fetch_fault(fault_a),
    .ld_start(ld_start), .ld_byte_valid(ld_byte_valid), .ld_byte(ld_byte), .ld_end(ld_end),
    .ld_busy(busy_a), .cpu_hold(hold_a), .ld_done(done_a), .ld_err(err_a), .ld_word_count(cnt_a));

  instr_mem_bootload #(.ADDR_W(32), .DEPTH_WORDS(DEPTH), .READ_LAT(2), .NOP_WORD(NOP)) dut_b (
    .clk(clk), .rst_n(rst_n), .fetch_en(fetch_en), .fetch_addr(fetch_addr),
    .instr(instr_b), .instr_valid(valid_b), .fetch_fault(fault_b),
    .ld_start(ld_start), .ld_byte_valid(ld_byte_valid), .ld_byte(ld_byte), .ld_end(ld_end),
    .ld_busy(busy_b), .cpu_hold(hold_b), .ld_done(done_b), .ld_err(err_b), .ld_word_count(cnt_b));

  int n_run  = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_run++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: memory image, byte queue for the word being assembled, and the two
  // most recent fetch results (newest is the READ_LAT=1 output, older the READ_LAT=2 output).
  typedef struct packed {
    logic [31:0] instr;
    logic        valid;
    logic        fault;
  } frec_t;

  logic [31:0] m_mem [DEPTH];
  logic [7:0]  m_q [$];
  frec_t       h1, h2;
  bit          m_loading, m_done, m_err;
  int          m_wptr, m_cnt;

  function automatic frec_t fetch_ref(input logic [31:0] a);
    frec_t r;
    int    idx;
    idx = int'(a >> 2);
    if (a[1:0] != 2'b00 || (a >> 2) >= 32'(DEPTH)) r = '{NOP, 1'b1, 1'b1};
    else                                           r = '{m_mem[idx], 1'b1, 1'b0};
    return r;
  endfunction

  task automatic model_clear_load();
    m_q.delete();
    m_wptr = 0;
    m_cnt  = 0;
    m_err  = 1'b0;
  endtask

  task automatic model_edge();
    frec_t r;
    bit    busy_pre;
    if (!rst_n) begin
      h1 = '{NOP, 1'b0, 1'b0};
      h2 = h1;
      m_loading = 1'b0;
      m_done    = 1'b0;
      model_clear_load();
      return;
    end
    busy_pre = m_loading || m_done;
    if (fetch_en) begin
      r  = busy_pre ? '{NOP, 1'b0, 1'b0} : fetch_ref(fetch_addr);
      h2 = h1;
      h1 = r;
    end
    if (m_done) begin
      m_done = 1'b0;
    end else if (m_loading) begin
      if (ld_start) begin
        model_clear_load();
      end else begin
        if (ld_byte_valid) begin
          m_q.push_back(ld_byte);
          if (m_q.size() == 4) begin
            m_mem[m_wptr] = {m_q[3], m_q[2], m_q[1], m_q[0]};
            m_wptr++;
            m_cnt++;
            m_q.delete();
            if (m_wptr == int'(DEPTH)) begin
              m_loading = 1'b0;
              m_done    = 1'b1;
            end
          end
        end
        if (m_loading && ld_end) begin
          if (m_q.size() != 0) m_err = 1'b1;
          m_q.delete();
          m_loading = 1'b0;
          m_done    = 1'b1;
        end
      end
    end else if (ld_start) begin
      m_loading = 1'b1;
      model_clear_load();
    end
  endtask

  // One clock: update the model at the edge, then compare both instances just after it.
  task automatic step();
    bit exp_busy;
    @(posedge clk);
    model_edge();
    #1;
    exp_busy = m_loading || m_done;
    chk("a_instr", instr_a, h1.instr);
    chk("a_valid", 32'(valid_a), 32'(h1.valid));
    chk("a_fault", 32'(fault_a), 32'(h1.fault));
    chk("b_instr", instr_b, h2.instr);
    chk("b_valid", 32'(valid_b), 32'(h2.valid));
    chk("b_fault", 32'(fault_b), 32'(h2.fault));
    chk("a_busy", 32'(busy_a), 32'(exp_busy));
    chk("a_hold", 32'(hold_a), 32'(exp_busy));
    chk("b_hold", 32'(hold_b), 32'(exp_busy));
    chk("a_done", 32'(done_a), 32'(m_done));
    chk("b_done", 32'(done_b), 32'(m_done));
    chk("a_err", 32'(err_a), 32'(m_err));
    chk("a_cnt", 32'(cnt_a), 32'(m_cnt));
    chk("b_cnt", 32'(cnt_b), 32'(m_cnt));
  endtask

  task automatic pulse_start();
    ld_start = 1'b1;
    step();
    ld_start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input bit with_end);
    ld_byte_valid = 1'b1;
    ld_byte       = b;
    ld_end        = with_end;
    step();
    ld_byte_valid = 1'b0;
    ld_end        = 1'b0;
  endtask

  task automatic pulse_end();
    ld_end = 1'b1;
    step();
    ld_end = 1'b0;
  endtask

  task automatic fetch(input logic [31:0] a);
    fetch_en   = 1'b1;
    fetch_addr = a;
    step();
  endtask

  function automatic logic [31:0] rand_addr();
    logic [31:0] a;
    case ($urandom_range(0, 9))
      0:       a = 32'($urandom);
      1:       a = 32'($urandom_range(0, 4 * DEPTH + 7));
      2:       a = 32'(4 * DEPTH) + (32'($urandom_range(0, 7)) << 2);
      default: a = 32'($urandom_range(0, DEPTH - 1)) << 2;
    endcase
    return a;
  endfunction

  typedef struct {
    logic [31:0] addr;
    logic [31:0] exp_instr;
    logic        exp_fault;
  } vec_t;

  vec_t        tbl [7];
  logic [31:0] held_a, held_b;

  initial begin
    tbl[0] = '{32'h0000_0000, 32'h0010_0093, 1'b0};
    tbl[1] = '{32'h0000_0004, NOP,           1'b0};
    tbl[2] = '{32'h0000_0002, NOP,           1'b1};
    tbl[3] = '{32'(4 * DEPTH), NOP,          1'b1};
    tbl[4] = '{32'h0000_003C, NOP,           1'b0};
    tbl[5] = '{32'h4000_0000, NOP,           1'b1};
    tbl[6] = '{32'h0000_0001, NOP,           1'b1};

    for (int i = 0; i < int'(DEPTH); i++) m_mem[i] = NOP;
    rst_n = 1'b0; fetch_en = 1'b0; fetch_addr = '0;
    ld_start = 1'b0; ld_byte_valid = 1'b0; ld_byte = '0; ld_end = 1'b0;

    // Reset state.
    step();
    step();
    rst_n = 1'b1;

    // Fetches of the untouched image return NOP with valid set.
    fetch(32'h0);
    chk("t1_instr0", instr_a, NOP);
    chk("t1_valid0", 32'(valid_a), 32'd1);
    fetch(32'h4);
    chk("t1_fault4", 32'(fault_a), 32'd0);
    fetch_en = 1'b0;

    // One-word load with ld_end.
    pulse_start();
    send_byte(8'h93, 1'b0);
    send_byte(8'h00, 1'b0);
    send_byte(8'h10, 1'b0);
    send_byte(8'h00, 1'b0);
    pulse_end();
    chk("t2_done", 32'(done_a), 32'd1);
    chk("t2_cnt", 32'(cnt_a), 32'd1);
    chk("t2_err", 32'(err_a), 32'd0);
    step();
    chk("t2_done_gone", 32'(done_a), 32'd0);

    // Table of fetches including misaligned and out-of-range addresses.
    for (int i = 0; i < 7; i++) begin
      fetch(tbl[i].addr);
      chk("tbl_instr", instr_a, tbl[i].exp_instr);
      chk("tbl_fault", 32'(fault_a), 32'(tbl[i].exp_fault));
      chk("tbl_valid", 32'(valid_a), 32'd1);
    end
    fetch_en = 1'b0;

    // Partial word at ld_end: error, one word counted, word 1 untouched.
    pulse_start();
    for (int i = 0; i < 6; i++) send_byte(8'(8'hA0 + i), 1'b0);
    pulse_end();
    chk("t5_err", 32'(err_a), 32'd1);
    chk("t5_cnt", 32'(cnt_a), 32'd1);
    step();
    fetch(32'h4);
    chk("t5_mem1", instr_a, NOP);
    fetch(32'h0);
    chk("t5_mem0", instr_a, 32'hA3A2_A1A0);
    chk("t5_err_sticky", 32'(err_a), 32'd1);
    fetch_en = 1'b0;

    // Reset in the middle of a load: no done pulse, busy drops.
    pulse_start();
    for (int i = 0; i < 5; i++) send_byte(8'($urandom), 1'b0);
    rst_n = 1'b0;
    step();
    chk("rst_busy", 32'(busy_a), 32'd0);
    chk("rst_done", 32'(done_a), 32'd0);
    rst_n = 1'b1;
    step();
    chk("rst_done2", 32'(done_a), 32'd0);

    // Full image without ld_end: auto-finish, trailing bytes ignored.
    pulse_start();
    for (int i = 0; i < int'(4 * DEPTH); i++) send_byte(8'($urandom), 1'b0);
    chk("t6_done", 32'(done_a), 32'd1);
    chk("t6_cnt", 32'(cnt_a), 32'(DEPTH));
    for (int i = 0; i < 4; i++) send_byte(8'($urandom), i == 3);
    chk("t6_cnt_after", 32'(cnt_a), 32'(DEPTH));
    chk("t6_err", 32'(err_a), 32'd0);

    // READ_LAT=2 stall: outputs hold for three cycles, then the stream resumes intact.
    fetch(32'h0);
    fetch(32'h4);
    held_a = instr_a;
    held_b = instr_b;
    chk("t4_pre_b", instr_b, m_mem[0]);
    fetch_en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      fetch_addr = rand_addr();
      step();
      chk("t4_hold_a", instr_a, held_a);
      chk("t4_hold_b", instr_b, held_b);
    end
    fetch(32'h8);
    chk("t4_resume1", instr_b, m_mem[1]);
    fetch(32'hC);
    chk("t4_resume2", instr_b, m_mem[2]);

    // Randomized mix of loads and fetch bursts against the model.
    for (int it = 0; it < 150; it++) begin
      if ($urandom_range(0, 3) == 0) begin
        pulse_start();
        for (int b = 0; b < int'($urandom_range(0, 22)); b++) begin
          fetch_en   = 1'($urandom_range(0, 1));
          fetch_addr = rand_addr();
          if ($urandom_range(0, 15) == 0) begin
            pulse_start();
          end else if ($urandom_range(0, 3) == 0) begin
            step();
          end else begin
            send_byte(8'($urandom), 1'b0);
          end
        end
        if ($urandom_range(0, 1) == 1) send_byte(8'($urandom), 1'b1);
        else                           pulse_end();
        step();
      end else begin
        for (int c = 0; c < 10; c++) begin
          fetch_en      = ($urandom_range(0, 3) != 0);
          fetch_addr    = rand_addr();
          ld_byte_valid = 1'($urandom_range(0, 1));
          ld_byte       = 8'($urandom);
          ld_end        = ($urandom_range(0, 7) == 0);
          step();
        end
        ld_byte_valid = 1'b0;
        ld_end        = 1'b0;
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
